cpu_mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit RISC core. It replaces the single-cycle combinational control decode.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Uses valid/ack handshakes to instruction and data memory.
- Applies per-opcode execute latency, so multiply and divide can be multi-cycle.
- Drives datapath enables and muxes. The datapath returns the opcode, the immediate bit and the flags.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_mc_decode.sv | 55 +++++
 rtl/cpu_mc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cpu_mc_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle control sequencer: opcode map, ALU encoding,
// FSM states, writeback/PC mux selects and instruction classes.
package cpu_pkg;

  typedef enum logic [4:0] {
    OPC_ADD  = 5'd0,  OPC_SUB  = 5'd1,  OPC_MUL  = 5'd2,  OPC_DIV  = 5'd3,
    OPC_MOD  = 5'd4,  OPC_CMP  = 5'd5,  OPC_AND  = 5'd6,  OPC_OR   = 5'd7,
    OPC_NOT  = 5'd8,  OPC_MOV  = 5'd9,  OPC_LSL  = 5'd10, OPC_LSR  = 5'd11,
    OPC_ASR  = 5'd12, OPC_NOP  = 5'd13, OPC_LD   = 5'd14, OPC_ST   = 5'd15,
    OPC_BEQ  = 5'd16, OPC_BGT  = 5'd17, OPC_B    = 5'd18, OPC_CALL = 5'd19,
    OPC_RET  = 5'd20
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_MUL = 4'd2,  ALU_DIV = 4'd3,
    ALU_MOD = 4'd4, ALU_AND = 4'd5, ALU_OR  = 4'd6,  ALU_NOT = 4'd7,
    ALU_MOV = 4'd8, ALU_LSL = 4'd9, ALU_LSR = 4'd10, ALU_ASR = 4'd11,
    ALU_NOP = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM    = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_RA = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_CMP, CLS_LD, CLS_ST, CLS_BEQ, CLS_BGT, CLS_B,
    CLS_CALL, CLS_RET, CLS_NOP, CLS_ILLEGAL, CLS_HALT
  } instr_class_e;

  typedef enum logic [1:0] {LAT_SEL_ONE, LAT_SEL_MUL, LAT_SEL_DIV} lat_sel_e;

  localparam int LAT_ONE = 1;

endpackage

// File: rtl/cpu_mc_decode.sv
// Combinational opcode decode: ALU operation, instruction class, register-file
// write intent and execute-latency select.
import cpu_pkg::*;

module cpu_mc_decode #(
  parameter int OPC_W    = 5,
  parameter int HALT_OPC = 31
) (
  input  logic [OPC_W-1:0] opc,
  output alu_op_e          alu_op,
  output instr_class_e     cls,
  output logic             writes_rf,
  output lat_sel_e         lat_sel
);

  logic [4:0] op5;
  assign op5 = 5'(opc);

  always_comb begin
    alu_op    = ALU_NOP;
    cls       = CLS_ILLEGAL;
    writes_rf = 1'b0;
    lat_sel   = LAT_SEL_ONE;
    if (opc == OPC_W'(HALT_OPC)) begin
      cls = CLS_HALT;
    end else begin
      case (opcode_e'(op5))
        OPC_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD; writes_rf = 1'b1; end
        OPC_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB; writes_rf = 1'b1; end
        OPC_MUL:  begin cls = CLS_ALU; alu_op = ALU_MUL; writes_rf = 1'b1; lat_sel = LAT_SEL_MUL; end
        OPC_DIV:  begin cls = CLS_ALU; alu_op = ALU_DIV; writes_rf = 1'b1; lat_sel = LAT_SEL_DIV; end
        OPC_MOD:  begin cls = CLS_ALU; alu_op = ALU_MOD; writes_rf = 1'b1; lat_sel = LAT_SEL_DIV; end
        OPC_CMP:  begin cls = CLS_CMP; alu_op = ALU_SUB; end
        OPC_AND:  begin cls = CLS_ALU; alu_op = ALU_AND; writes_rf = 1'b1; end
        OPC_OR:   begin cls = CLS_ALU; alu_op = ALU_OR;  writes_rf = 1'b1; end
        OPC_NOT:  begin cls = CLS_ALU; alu_op = ALU_NOT; writes_rf = 1'b1; end
        OPC_MOV:  begin cls = CLS_ALU; alu_op = ALU_MOV; writes_rf = 1'b1; end
        OPC_LSL:  begin cls = CLS_ALU; alu_op = ALU_LSL; writes_rf = 1'b1; end
        OPC_LSR:  begin cls = CLS_ALU; alu_op = ALU_LSR; writes_rf = 1'b1; end
        OPC_ASR:  begin cls = CLS_ALU; alu_op = ALU_ASR; writes_rf = 1'b1; end
        OPC_NOP:  cls = CLS_NOP;
        // Loads and stores use the ALU adder for address generation.
        OPC_LD:   begin cls = CLS_LD;  alu_op = ALU_ADD; writes_rf = 1'b1; end
        OPC_ST:   begin cls = CLS_ST;  alu_op = ALU_ADD; end
        OPC_BEQ:  cls = CLS_BEQ;
        OPC_BGT:  cls = CLS_BGT;
        OPC_B:    cls = CLS_B;
        OPC_CALL: begin cls = CLS_CALL; writes_rf = 1'b1; end
        OPC_RET:  cls = CLS_RET;
        default:  cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory handshakes
// and per-opcode execute latency; outputs decode from registered state.
import cpu_pkg::*;

module cpu_mc_sequencer #(
  parameter int OPC_W    = 5,
  parameter int ALU_OP_W = 4,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int HALT_OPC = 31
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ack,
  output logic                ir_we,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                imm,
  input  logic                flag_eq,
  input  logic                flag_gt,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                is_imm,
  output logic                flags_we,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                rf_we,
  output logic                rf_wsel_ra,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                instr_retired,
  output logic                illegal,
  output logic                halted,
  output logic [2:0]          state
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_e       cur, nxt;
  logic [OPC_W-1:0] opc_q, dec_opc;
  logic             imm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_load;

  alu_op_e      dec_alu;
  instr_class_e cls;
  logic         writes_rf;
  lat_sel_e     lat_sel;

  // In DECODE the live IR field drives the decoder; afterwards only the captured copy does.
  assign dec_opc = (cur == S_DECODE) ? opcode : opc_q;

  cpu_mc_decode #(.OPC_W(OPC_W), .HALT_OPC(HALT_OPC)) u_decode (
    .opc       (dec_opc),
    .alu_op    (dec_alu),
    .cls       (cls),
    .writes_rf (writes_rf),
    .lat_sel   (lat_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= S_RESET;
      opc_q <= '0;
      imm_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cur   <= nxt;
      cnt_q <= cnt_d;
      if (cur == S_DECODE) begin
        // Undefined opcodes are replaced by NOP so they retire harmlessly.
        opc_q <= (cls == CLS_ILLEGAL) ? OPC_W'(OPC_NOP) : opcode;
        imm_q <= imm;
      end
    end
  end

  always_comb begin
    case (lat_sel)
      LAT_SEL_MUL: lat_load = CNT_W'(MUL_LAT - 1);
      LAT_SEL_DIV: lat_load = CNT_W'(DIV_LAT - 1);
      default:     lat_load = CNT_W'(LAT_ONE - 1);
    endcase
  end

  always_comb begin
    nxt           = cur;
    cnt_d         = cnt_q;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    alu_op        = '0;
    is_imm        = 1'b0;
    flags_we      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    rf_we         = 1'b0;
    rf_wsel_ra    = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    halted        = 1'b0;
    case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) nxt = S_DECODE;
      end
      S_DECODE: begin
        illegal = (cls == CLS_ILLEGAL);
        if (cls == CLS_HALT) begin
          nxt = S_HALT;
        end else begin
          nxt   = S_EXEC;
          cnt_d = lat_load;
        end
      end
      S_EXEC: begin
        alu_op = ALU_OP_W'(dec_alu);
        is_imm = imm_q;
        if (cnt_q == '0) begin
          flags_we = (cls == CLS_CMP);
          nxt      = (cls == CLS_LD || cls == CLS_ST) ? S_MEM : S_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_ST);
        if (dmem_ack) nxt = S_WB;
      end
      S_WB: begin
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        rf_we         = writes_rf;
        rf_wsel_ra    = (cls == CLS_CALL);
        if (cls == CLS_LD)   wb_sel = WB_MEM;
        if (cls == CLS_CALL) wb_sel = WB_PC4;
        // Flags are read here, so a CMP directly ahead of a branch is honoured.
        case (cls)
          CLS_RET:            pc_sel = PC_RA;
          CLS_B, CLS_CALL:    pc_sel = PC_BRANCH;
          CLS_BEQ: if (flag_eq) pc_sel = PC_BRANCH;
          CLS_BGT: if (flag_gt) pc_sel = PC_BRANCH;
          default:            pc_sel = PC_PLUS4;
        endcase
        nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: nxt = S_RESET;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_mc_sequencer.sv
// Scoreboard bench: each issued instruction pushes its expected writeback profile;
// a negedge monitor accumulates per-instruction activity and compares on retire.
module tb_cpu_mc_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req, imem_ack, ir_we;
  logic [4:0] opcode;
  logic       imm, flag_eq, flag_gt;
  logic [3:0] alu_op;
  logic       is_imm, flags_we, dmem_req, dmem_we, dmem_ack;
  logic       rf_we, rf_wsel_ra, pc_we, instr_retired, illegal, halted;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;

  always #5 clk = ~clk;

  cpu_mc_sequencer #(.OPC_W(5), .ALU_OP_W(4), .MUL_LAT(2), .DIV_LAT(8), .HALT_OPC(31)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .opcode(opcode), .imm(imm), .flag_eq(flag_eq), .flag_gt(flag_gt), .alu_op(alu_op),
    .is_imm(is_imm), .flags_we(flags_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .rf_we(rf_we), .rf_wsel_ra(rf_wsel_ra), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .instr_retired(instr_retired), .illegal(illegal),
    .halted(halted), .state(state)
  );

  typedef struct {
    string name;
    int rf_we, ra, wb, pc, lat, memc, dwe, imm, ill, fw, alu;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: per-instruction accumulators reset on each IR load.
  int   cyc = 0, t_start = 0, mem_cyc = 0, flags_cnt = 0;
  int   seen_dwe = 0, seen_imm = 0, seen_ill = 0, seen_alu = 0;
  exp_t got;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mem_cyc = 0; flags_cnt = 0; seen_dwe = 0; seen_imm = 0; seen_ill = 0;
    end else begin
      if (ir_we) begin
        t_start = cyc; mem_cyc = 0; flags_cnt = 0;
        seen_dwe = 0; seen_imm = 0; seen_ill = 0; seen_alu = 0;
      end
      if (state == S_EXEC) begin
        if (is_imm) seen_imm = 1;
        seen_alu = int'(alu_op);
      end
      if (dmem_req) begin
        mem_cyc++;
        if (dmem_we) seen_dwe = 1;
      end
      if (illegal) seen_ill = 1;
      if (flags_we) flags_cnt++;
      if (instr_retired) begin
        if (sb.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          got = sb.pop_front();
          check({got.name, ".rf_we"},      int'(rf_we),      got.rf_we);
          check({got.name, ".rf_wsel_ra"}, int'(rf_wsel_ra), got.ra);
          check({got.name, ".wb_sel"},     int'(wb_sel),     got.wb);
          check({got.name, ".pc_sel"},     int'(pc_sel),     got.pc);
          check({got.name, ".pc_we"},      int'(pc_we),      1);
          check({got.name, ".latency"},    cyc - t_start + 1, got.lat);
          check({got.name, ".dmem_cycles"}, mem_cyc,         got.memc);
          check({got.name, ".dmem_we"},    seen_dwe,         got.dwe);
          check({got.name, ".is_imm"},     seen_imm,         got.imm);
          check({got.name, ".illegal"},    seen_ill,         got.ill);
          check({got.name, ".flags_we"},   flags_cnt,        got.fw);
          check({got.name, ".alu_op"},     seen_alu,         got.alu);
        end
      end
    end
  end

  task automatic fetch(input int opc, input bit im, input bit feq, input bit fgt);
    int k = 0;
    while (!imem_req && k < 32) begin @(posedge clk); #1; k++; end
    check("imem_req_wait", int'(imem_req), 1);
    opcode = 5'(opc); imm = im; flag_eq = feq; flag_gt = fgt; imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
  endtask

  task automatic issue(input string nm, input int opc, input bit im, input bit feq,
                       input bit fgt, input int dwait, input int rfw, input int ra,
                       input int wb, input int pc, input int lat, input int memc,
                       input int dwe, input int ill, input int fw, input alu_op_e alu);
    exp_t e;
    int   k = 0;
    e.name = nm; e.rf_we = rfw; e.ra = ra; e.wb = wb; e.pc = pc; e.lat = lat;
    e.memc = memc; e.dwe = dwe; e.imm = int'(im); e.ill = ill; e.fw = fw; e.alu = int'(alu);
    sb.push_back(e);
    fetch(opc, im, feq, fgt);
    @(posedge clk); #1;
    // Scramble the IR fields once DECODE is over: only captured copies may matter.
    opcode = ~5'(opc); imm = ~im;
    while (state != S_FETCH && k < 64) begin
      if (state == S_MEM) begin
        repeat (dwait) @(posedge clk);
        #1 dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      k++;
    end
    check({nm, ".back_to_fetch"}, int'(state), int'(S_FETCH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0; imm = 1'b0;
    flag_eq = 1'b0; flag_gt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset.state",    int'(state),    int'(S_RESET));
    check("reset.imem_req", int'(imem_req), 0);
    check("reset.halted",   int'(halted),   0);
    check("reset.pc_we",    int'(pc_we),    0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset.state", int'(state), int'(S_FETCH));

    //    name         opc im eq gt dw rf ra wb pc lat mem dwe ill fw alu
    issue("add_imm",     0, 1, 0, 0, 0, 1, 0, 0, 0,  4, 0, 0, 0, 0, ALU_ADD);
    issue("mul",         2, 0, 0, 0, 0, 1, 0, 0, 0,  5, 0, 0, 0, 0, ALU_MUL);
    issue("div",         3, 0, 0, 0, 0, 1, 0, 0, 0, 11, 0, 0, 0, 0, ALU_DIV);
    issue("mod",         4, 1, 0, 0, 0, 1, 0, 0, 0, 11, 0, 0, 0, 0, ALU_MOD);
    issue("ld_wait3",   14, 1, 0, 0, 3, 1, 0, 1, 0,  8, 4, 0, 0, 0, ALU_ADD);
    issue("st",         15, 0, 0, 0, 0, 0, 0, 0, 0,  5, 1, 1, 0, 0, ALU_ADD);
    issue("cmp",         5, 0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 1, ALU_SUB);
    issue("beq_taken",  16, 0, 1, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, ALU_NOP);
    issue("beq_not",    16, 0, 0, 1, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, ALU_NOP);
    issue("bgt_taken",  17, 0, 0, 1, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, ALU_NOP);
    issue("bgt_not",    17, 0, 1, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, ALU_NOP);
    issue("b",          18, 0, 0, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, ALU_NOP);
    issue("call",       19, 0, 0, 0, 0, 1, 1, 2, 1,  4, 0, 0, 0, 0, ALU_NOP);
    issue("ret",        20, 0, 0, 0, 0, 0, 0, 0, 2,  4, 0, 0, 0, 0, ALU_NOP);
    issue("undef25",    25, 1, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 1, 0, ALU_NOP);
    issue("mov",         9, 0, 0, 0, 0, 1, 0, 0, 0,  4, 0, 0, 0, 0, ALU_MOV);
    issue("nop",        13, 0, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, ALU_NOP);

    // HALT: enter and stay, ignoring a stray fetch ack.
    fetch(31, 0, 0, 0);
    check("halt.decode_illegal", int'(illegal), 0);
    @(posedge clk); #1;
    check("halt.halted", int'(halted), 1);
    check("halt.state",  int'(state),  int'(S_HALT));
    repeat (3) @(posedge clk);
    #1 imem_ack = 1'b1;
    #1;
    check("halt.ir_we_ignored", int'(ir_we),    0);
    check("halt.imem_req",      int'(imem_req), 0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("halt.still_halted", int'(halted), 1);

    // Reset releases HALT.
    rst = 1'b1;
    #1;
    check("halt_rst.state",  int'(state),  int'(S_RESET));
    check("halt_rst.halted", int'(halted), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("halt_rst.fetch", int'(state), int'(S_FETCH));

    // Reset asserted mid-MEM with an outstanding data request.
    fetch(14, 0, 0, 0);
    k = 0;
    while (state != S_MEM && k < 16) begin @(posedge clk); #1; k++; end
    check("midmem.dmem_req_before", int'(dmem_req), 1);
    #2 rst = 1'b1;
    #1;
    check("midmem.dmem_req",  int'(dmem_req), 0);
    check("midmem.state",     int'(state),    int'(S_RESET));
    check("midmem.imem_req",  int'(imem_req), 0);
    check("midmem.retired",   int'(instr_retired), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midmem.fetch_after_release", int'(state),    int'(S_FETCH));
    check("midmem.imem_req_after",      int'(imem_req), 1);

    issue("add_after_rst", 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 0, ALU_ADD);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
